prog_loader: RTL and testbench

- Hardware replacement for the bench-driven program-load sequence. It accepts a word stream over a valid/ready handshake, decodes (address, data) records and writes them into program RAM through the RAM's input-mode port (mode, address, program word, write strobe).
- It holds the CPU idle until the load completes and passes an optional XOR checksum, then releases the CPU.
- Sits between an external host/UART front end and the RAM's input-mode pins; widths are parametrised for larger successors of the 4-bit core.

---
 rtl/prog_loader_pkg.sv | 13 +
 rtl/prog_loader_if.sv | 18 +
 rtl/prog_loader.sv | 164 ++++++++++++++++
 tb/tb_prog_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and error codes for the program loader.
//   IDLE..ERR  loader FSM states
//   ERR_*      values reported on err_code
package prog_loader_pkg;

   typedef enum logic [2:0] {IDLE, ADDR, DATA, WR, CSUM, FIN, ERR} state_e;

   localparam logic [1:0] ERR_NONE      = 2'd0;
   localparam logic [1:0] ERR_LAST_ADDR = 2'd1;
   localparam logic [1:0] ERR_OVF       = 2'd2;
   localparam logic [1:0] ERR_CSUM      = 2'd3;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: valid/ready word stream from the host front end into the loader.
//   s_valid  word valid (host)
//   s_data   stream word (host)
//   s_last   final data word of the load (host)
//   s_ready  loader accepts a word this cycle (loader)
interface prog_loader_if #(
   parameter int WORD_W = 8
) ();

   logic              s_valid;
   logic [WORD_W-1:0] s_data;
   logic              s_last;
   logic              s_ready;

   modport master (output s_valid, s_data, s_last, input s_ready);
   modport slave  (input s_valid, s_data, s_last, output s_ready);

endinterface

// File: rtl/prog_loader.sv
// prog_loader: decodes (address, data) records from a word stream, writes them into
// program RAM via its input-mode port and holds the CPU until a load succeeds.
//   clk, reset     system clock, synchronous active-high reset
//   start          one-cycle pulse beginning a load (ignored while busy)
//   s              stream slave port (s_valid, s_data, s_last in; s_ready out)
//   input_mode     RAM input-mode pin, high while loading
//   input_address  RAM write address
//   input_program  RAM write data
//   prog_we        one-cycle RAM write strobe
//   cpu_hold       keeps the CPU in reset while high
//   busy           load in progress
//   done, err      sticky completion / failure flags
//   err_code       failure cause
//   rec_count      records written in this load
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W   = 4,
   parameter int WORD_W   = 8,
   parameter int CHECK_EN = 1,
   parameter int MAX_REC  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   prog_loader_if.slave      s,
   output logic              input_mode,
   output logic [ADDR_W-1:0] input_address,
   output logic [WORD_W-1:0] input_program,
   output logic              prog_we,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   rec_count
);

   localparam logic [ADDR_W:0] MAX_Q = (ADDR_W+1)'(MAX_REC);
   localparam logic [ADDR_W:0] ONE_Q = (ADDR_W+1)'(1);

   state_e              state_q, state_d;
   logic                mode_q, mode_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   prog_q, prog_d;
   logic                hold_q, hold_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [1:0]          code_q, code_d;
   logic [ADDR_W:0]     rec_q, rec_d;
   logic [WORD_W-1:0]   csum_q, csum_d;
   logic                last_q, last_d;
   logic                xfer;

   // ready is a pure function of state so it never loops back through s_valid
   assign s.s_ready     = state_q inside {ADDR, DATA, CSUM};
   assign xfer          = s.s_valid & s.s_ready;
   assign prog_we       = state_q == WR;
   assign busy          = state_q inside {ADDR, DATA, WR, CSUM};
   assign input_mode    = mode_q;
   assign input_address = addr_q;
   assign input_program = prog_q;
   assign cpu_hold      = hold_q;
   assign done          = done_q;
   assign err           = err_q;
   assign err_code      = code_q;
   assign rec_count     = rec_q;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      addr_d  = addr_q;
      prog_d  = prog_q;
      hold_d  = hold_q;
      done_d  = done_q;
      err_d   = err_q;
      code_d  = code_q;
      rec_d   = rec_q;
      csum_d  = csum_q;
      last_d  = last_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = ADDR;
            hold_d  = 1'b1;
            mode_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
            rec_d   = '0;
            csum_d  = '0;
         end
         ADDR: if (xfer) begin
            addr_d = s.s_data[ADDR_W-1:0];
            csum_d = csum_q ^ s.s_data;
            if (s.s_last) begin
               state_d = ERR;
               code_d  = ERR_LAST_ADDR;
            end else if (rec_q == MAX_Q) begin
               state_d = ERR;
               code_d  = ERR_OVF;
            end else begin
               state_d = DATA;
            end
         end
         DATA: if (xfer) begin
            prog_d  = s.s_data;
            csum_d  = csum_q ^ s.s_data;
            last_d  = s.s_last;
            state_d = WR;
         end
         WR: begin
            rec_d   = rec_q + ONE_Q;
            state_d = !last_q ? ADDR : (CHECK_EN != 0 ? CSUM : FIN);
         end
         // the accumulator holds every address and data word but not the checksum word
         CSUM: if (xfer) begin
            state_d = s.s_data == csum_q ? FIN : ERR;
            code_d  = s.s_data == csum_q ? code_q : ERR_CSUM;
         end
         FIN: begin
            done_d  = 1'b1;
            mode_d  = 1'b0;
            hold_d  = 1'b0;
            state_d = IDLE;
         end
         // CPU stays held after a failed load
         ERR: begin
            err_d   = 1'b1;
            mode_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         addr_q  <= '0;
         prog_q  <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         rec_q   <= '0;
         csum_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         addr_q  <= addr_d;
         prog_q  <= prog_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
         rec_q   <= rec_d;
         csum_q  <= csum_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed checks of two loaders (without / with checksum) sharing one host stream.
module tb_prog_loader;

   logic       clk = 1'b0, reset = 1'b1, start0 = 1'b0, start1 = 1'b0;
   logic       s_valid = 1'b0, s_last = 1'b0, sel = 1'b0, rdy;
   logic [7:0] s_data = 8'h00;
   int         cyc = 0, ncmp = 0, nfail = 0, first_x = 0, lastwe0 = 0;
   bit         mark = 1'b0;
   logic [11:0] log0[$], log1[$];

   logic       mode0, we0, hold0, busy0, done0, err0, mode1, we1, hold1, busy1, done1, err1;
   logic [3:0] addr0, addr1;
   logic [7:0] prog0, prog1;
   logic [1:0] code0, code1;
   logic [4:0] rec0, rec1;

   // {address, data} of the reference load
   logic [11:0] recs [6] = '{12'h903, 12'hA05, 12'h079, 12'h130, 12'h27A, 12'h380};

   prog_loader_if #(.WORD_W(8)) if0 ();
   prog_loader_if #(.WORD_W(8)) if1 ();

   assign if0.s_valid = s_valid;
   assign if0.s_data  = s_data;
   assign if0.s_last  = s_last;
   assign if1.s_valid = s_valid;
   assign if1.s_data  = s_data;
   assign if1.s_last  = s_last;
   assign rdy = sel ? if1.s_ready : if0.s_ready;

   prog_loader #(.ADDR_W(4), .WORD_W(8), .CHECK_EN(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .s(if0.slave),
      .input_mode(mode0), .input_address(addr0), .input_program(prog0), .prog_we(we0),
      .cpu_hold(hold0), .busy(busy0), .done(done0), .err(err0), .err_code(code0), .rec_count(rec0));

   prog_loader #(.ADDR_W(4), .WORD_W(8), .CHECK_EN(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .s(if1.slave),
      .input_mode(mode1), .input_address(addr1), .input_program(prog1), .prog_we(we1),
      .cpu_hold(hold1), .busy(busy1), .done(done1), .err(err1), .err_code(code1), .rec_count(rec1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (we0) begin
         log0.push_back({addr0, prog0});
         lastwe0 = cyc;
      end
      if (we1) log1.push_back({addr1, prog1});
   end

   function automatic logic [25:0] outs0();
      return {if0.s_ready, mode0, addr0, prog0, we0, hold0, busy0, done0, err0, code0, rec0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      int n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (!rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", {31'd0, rdy}, 32'd1);
      if (mark) begin
         first_x = cyc;
         mark = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic gap(input int gapmax);
      int g = $urandom_range(gapmax, 0);
      if (g > 0) begin
         s_valid = 1'b0;
         repeat (g) @(negedge clk);
      end
   endtask

   task automatic load6(input int gapmax, input bit poke);
      for (int i = 0; i < 6; i++) begin
         send({4'h0, recs[i][11:8]}, 1'b0);
         gap(gapmax);
         send(recs[i][7:0], i == 5);
         gap(gapmax);
         if (poke && i == 1) begin
            s_valid = 1'b0;
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
         end
      end
   endtask

   task automatic pulse(input bit w);
      if (w) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_hi(input int w, input string tag);
      int n = 0;
      while (!(w == 0 ? done0 : w == 1 ? done1 : err1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, n < 20}, 32'd1);
   endtask

   task automatic check_log(input logic [11:0] q[$], input string tag);
      check({tag, "_nwr"}, q.size(), 6);
      for (int i = 0; i < 6 && i < q.size(); i++) check({tag, "_wr"}, q[i], recs[i]);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_outs0", outs0(), {1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0});
      check("rst_hold1", hold1, 1);
      check("rst_ready1", if1.s_ready, 0);
      reset = 1'b0;
      @(negedge clk);

      // back-to-back load without checksum
      sel = 1'b0;
      log0.delete();
      pulse(0);
      check("t1_busy", busy0, 1);
      check("t1_mode", mode0, 1);
      mark = 1'b1;
      load6(0, 0);
      s_valid = 1'b0;
      wait_hi(0, "t1_done");
      check_log(log0, "t1");
      check("t1_rec", rec0, 6);
      check("t1_hold", hold0, 0);
      check("t1_mode_off", mode0, 0);
      check("t1_err", err0, 0);
      check("t1_latency", lastwe0 - first_x, 17);

      // good checksum: XOR of all twelve address and data words is 0xB6
      sel = 1'b1;
      log1.delete();
      pulse(1);
      load6(0, 0);
      send(8'hB6, 1'b0);
      s_valid = 1'b0;
      check("t2_fin_pre", done1, 0);
      @(negedge clk);
      check("t2_done", done1, 1);
      check_log(log1, "t2");
      check("t2_hold", hold1, 0);
      check("t2_rec", rec1, 6);

      // bad checksum
      log1.delete();
      pulse(1);
      check("t3_done_clr", done1, 0);
      check("t3_hold_set", hold1, 1);
      load6(0, 0);
      send(8'h5C, 1'b0);
      s_valid = 1'b0;
      wait_hi(2, "t3_err");
      check("t3_code", code1, 3);
      check("t3_hold", hold1, 1);
      check("t3_mode", mode1, 0);
      check("t3_done", done1, 0);
      check("t3_nwr", log1.size(), 6);

      // s_last on an address word
      log1.delete();
      pulse(1);
      check("t4_err_clr", err1, 0);
      send(8'h09, 1'b1);
      s_valid = 1'b0;
      check("t4_code", code1, 1);
      check("t4_err_pre", err1, 0);
      @(negedge clk);
      check("t4_err", err1, 1);
      check("t4_mode", mode1, 0);
      check("t4_hold", hold1, 1);
      check("t4_nwr", log1.size(), 0);

      // record overflow
      log1.delete();
      pulse(1);
      for (int i = 0; i < 16; i++) begin
         send(8'(i), 1'b0);
         send(8'(i * 17), 1'b0);
      end
      send(8'h05, 1'b0);
      s_valid = 1'b0;
      check("t5_code", code1, 2);
      check("t5_rec", rec1, 16);
      @(negedge clk);
      check("t5_err", err1, 1);
      check("t5_nwr", log1.size(), 16);
      check("t5_wr0", log1.size() > 0 ? log1[0] : 12'hXXX, 12'h000);
      check("t5_wr15", log1.size() > 15 ? log1[15] : 12'hXXX, 12'hFFF);

      // random valid gaps and a stray start mid-load
      sel = 1'b0;
      log0.delete();
      pulse(0);
      load6(1, 1);
      s_valid = 1'b0;
      wait_hi(0, "t6_done");
      check_log(log0, "t6");
      check("t6_rec", rec0, 6);
      check("t6_hold", hold0, 0);

      // reset while DATA of record 3 is pending
      log0.delete();
      pulse(0);
      for (int i = 0; i < 2; i++) begin
         send({4'h0, recs[i][11:8]}, 1'b0);
         send(recs[i][7:0], 1'b0);
      end
      send({4'h0, recs[2][11:8]}, 1'b0);
      s_valid = 1'b0;
      check("t7_in_data", prog0, recs[1][7:0]);
      reset = 1'b1;
      @(negedge clk);
      check("t7_rst_outs0", outs0(), {1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0});
      reset = 1'b0;
      @(negedge clk);
      log0.delete();
      pulse(0);
      load6(0, 0);
      s_valid = 1'b0;
      wait_hi(0, "t7_done");
      check_log(log0, "t7");
      check("t7_rec", rec0, 6);
      check("t7_hold", hold0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
